mimosa_caretaker: RTL
=====================

MIMOSA_CARETAKER -- requirements
Module: mimosa_caretaker

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4: clk cycles per model_clk phase (legal 2..255).
REQ-002 SHALL have parameter COOLDOWN, default 2: idle model periods after any nonzero stimulus (legal 0..15).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 en  in  1  run enable; sampled only in IDLE and at end of each HIGH phase.
REQ-006 energy_ind  in  2  energy range class, 0=lowest..3=highest.
REQ-007 stress_ind  in  2  stress range class, same encoding.
REQ-008 pleasure_ind  in  2  pleasure range class, same encoding.
REQ-009 emotion  in  8  mood model emotion word, opaque, compared for change only.
REQ-010 model_clk  out  1  generated clock for the mood model (drives its ui_in[0]).
REQ-011 stim  out  7  stimulus word for the mood model (drives its ui_in[7:1]).
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 change_cnt  out  8  saturating count of model periods with changed emotion.

Function
REQ-014 SHALL implement FSM states IDLE, LOW, HIGH; model_clk=1 only in HIGH.
REQ-015 IDLE: model_clk=0, stim=0; if en=1, enter LOW next cycle.
REQ-016 LOW and HIGH each SHALL last exactly HALF_PERIOD cycles; LOW->HIGH unconditional.
REQ-017 End of HIGH: en=1 -> LOW, en=0 -> IDLE; model period = 2*HALF_PERIOD cycles.
REQ-018 stim SHALL change only on the cycle entering LOW and stay constant through LOW and HIGH (setup >= HALF_PERIOD before rising model_clk).
REQ-019 On entering LOW, stim SHALL be decided from indicators sampled that cycle, priority order:
  - cooldown counter > 0 -> stim=0, counter decrements by 1;
  - stress_ind==3 -> stim=STIM_SOOTHE;
  - pleasure_ind==0 -> stim=STIM_PLAY;
  - energy_ind==0 -> stim=STIM_REST;
  - else stim=0.
REQ-020 Exactly one stimulus bit SHALL be set in any nonzero stim.
REQ-021 Nonzero stim SHALL load cooldown counter with COOLDOWN on the same cycle; COOLDOWN=0 allows stimulus every period.
REQ-022 On entering LOW, emotion SHALL be compared with the value latched at the previous LOW entry; if different, change_cnt increments, saturating at 255.
REQ-023 First LOW entry after reset SHALL latch emotion without counting a change.
REQ-024 Entering IDLE SHALL force stim=0 and preserve cooldown counter, emotion latch and change_cnt.
REQ-025 Indicator or emotion changes outside the LOW-entry cycle SHALL have no effect.

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE, model_clk=0, stim=0, busy=0, change_cnt=0, cooldown=0, phase counter=0, emotion latch invalid.
REQ-027 rst asserted mid-period SHALL abort the period with no further model_clk edge; release resumes from IDLE.

Structure
REQ-028 Shared package mimosa_pkg SHALL hold the FSM state enum and stimulus constants: STIM_SOOTHE=7'b0000001, STIM_PLAY=7'b0000010, STIM_REST=7'b0000100, plus indicator level names LVL_MIN=0, LVL_MAX=3.
REQ-029 Phase timing SHALL be one sub-module, mimosa_phase_timer (counts HALF_PERIOD, pulses done); decision logic and counters stay in mimosa_caretaker.

Verification
REQ-030 Reset, en=1, indicators (2,1,1): busy=1 next cycle; model_clk low 4 / high 4 cycles repeating; stim=0 throughout.
REQ-031 stress_ind=3, pleasure_ind=0 from reset: first period stim=0000001; next 2 periods stim=0; 4th period stim=0000001 again.
REQ-032 stress_ind=1, pleasure_ind=0, energy_ind=0: stim=0000010 (PLAY beats REST); COOLDOWN=0 build: stim=0000010 every period.
REQ-033 Emotion toggles 0x01/0x02 each period for 300 periods: change_cnt reaches 255 and holds; constant emotion leaves change_cnt=0.
REQ-034 Drop en mid-HIGH: HIGH completes its 4 cycles, then IDLE, stim=0, busy=0; raise en: LOW resumes, remaining cooldown honoured.
REQ-035 Assert rst 2 cycles into HIGH: model_clk, stim, change_cnt zero same cycle (async), no further model_clk rise until en after release.

Source files
------------

// File: rtl/mimosa_pkg.sv
// Shared definitions for the mimosa caretaker: FSM states, stimulus words
// and indicator level names.
package mimosa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  // Each stimulus drives exactly one bit of the mood model's ui_in[7:1].
  localparam logic [6:0] STIM_NONE   = 7'b0000000;
  localparam logic [6:0] STIM_SOOTHE = 7'b0000001;
  localparam logic [6:0] STIM_PLAY   = 7'b0000010;
  localparam logic [6:0] STIM_REST   = 7'b0000100;

  localparam logic [1:0] LVL_MIN = 2'd0;
  localparam logic [1:0] LVL_MAX = 2'd3;

endpackage

// File: rtl/mimosa_phase_timer.sv
// Counts the clk cycles of one model_clk phase and pulses done on the last
// cycle of that phase; held at zero while inactive.
module mimosa_phase_timer #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic done
);

  logic [7:0] cnt_reg;

  assign done = active && (cnt_reg == 8'(HALF_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 8'd0;
    end else if (!active || done) begin
      cnt_reg <= 8'd0;
    end else begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/mimosa_caretaker.sv
// Generates the mood model clock and picks one care stimulus per model period
// from the indicator classes, with a cooldown and an emotion-change counter.
module mimosa_caretaker
  import mimosa_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int COOLDOWN    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] energy_ind,
  input  logic [1:0] stress_ind,
  input  logic [1:0] pleasure_ind,
  input  logic [7:0] emotion,
  output logic       model_clk,
  output logic [6:0] stim,
  output logic       busy,
  output logic [7:0] change_cnt
);

  state_t     state_reg, state_next;
  logic       phase_done;
  logic       enter_low;
  logic [6:0] stim_reg, stim_next, decided;
  logic [3:0] cool_reg, cool_next;
  logic [7:0] latch_reg, latch_next;
  logic       valid_reg, valid_next;
  logic [7:0] cnt_reg, cnt_next;

  mimosa_phase_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .active(state_reg != IDLE),
    .done  (phase_done)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en) state_next = LOW;
      LOW:     if (phase_done) state_next = HIGH;
      HIGH:    if (phase_done) state_next = en ? LOW : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_low = (state_next == LOW) && (state_reg != LOW);

  always_comb begin
    decided = STIM_NONE;
    if (stress_ind == LVL_MAX) begin
      decided = STIM_SOOTHE;
    end else if (pleasure_ind == LVL_MIN) begin
      decided = STIM_PLAY;
    end else if (energy_ind == LVL_MIN) begin
      decided = STIM_REST;
    end
  end

  // Stimulus and cooldown only move at LOW entry so stim is stable a full
  // phase before the rising model_clk edge.
  always_comb begin
    stim_next = stim_reg;
    cool_next = cool_reg;
    if (enter_low) begin
      if (cool_reg != 4'd0) begin
        stim_next = STIM_NONE;
        cool_next = cool_reg - 4'd1;
      end else begin
        stim_next = decided;
        if (decided != STIM_NONE) cool_next = 4'(COOLDOWN);
      end
    end else if (state_next == IDLE) begin
      stim_next = STIM_NONE;
    end
  end

  always_comb begin
    latch_next = latch_reg;
    valid_next = valid_reg;
    cnt_next   = cnt_reg;
    if (enter_low) begin
      latch_next = emotion;
      valid_next = 1'b1;
      if (valid_reg && (emotion != latch_reg) && (cnt_reg != 8'hFF)) begin
        cnt_next = cnt_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      stim_reg  <= STIM_NONE;
      cool_reg  <= 4'd0;
      latch_reg <= 8'd0;
      valid_reg <= 1'b0;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      stim_reg  <= stim_next;
      cool_reg  <= cool_next;
      latch_reg <= latch_next;
      valid_reg <= valid_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign model_clk  = (state_reg == HIGH);
  assign busy       = (state_reg != IDLE);
  assign stim       = stim_reg;
  assign change_cnt = cnt_reg;

endmodule
